cfg_cmd_parser: RTL
===================

Name: cfg_cmd_parser

Overview:
Single-clock command parser between the UART receive FIFO (show-ahead, empty-flag read interface) and the configuration bus that programs the clock divider, UART and VGA blocks. It assembles framed byte commands from the UART stream and validates them. Each valid command becomes one configuration-bus write with a valid/ready handshake. Every outcome produces a 4-bit status code that the LED manager displays.

Parameters:
HEADER, 8'hA5, frame start byte
MAX_ADDR, 4'd11, highest legal configuration address
TIMEOUT, 50000, max idle cycles between frame bytes, and max wait for c_ready
CNT_W, 16, width of timeout counter (must hold TIMEOUT)

Ports:
clk  in  1  system clock
rst  in  1  reset; one clock; reset is synchronous and active-high
rx_data  in  8  FIFO head byte, valid whenever rx_empty=0
rx_empty  in  1  FIFO empty flag
rx_rd  out  1  pop strobe; the byte on rx_data is consumed in the same cycle
c_valid  out  1  configuration write request
c_addr  out  4  configuration address
c_data  out  14  configuration data
c_ready  in  1  AND of all slave ready lines
status  out  4  result code
status_valid  out  1  one-cycle strobe qualifying status

Behaviour:
- Reset: state IDLE; rx_rd=0, c_valid=0, c_addr=0, c_data=0, status=0, status_valid=0; timeout counter=0. Reset mid-frame or mid-write discards everything. c_valid drops on the cycle after rst is sampled high.
- rx_rd = !rx_empty && state in {IDLE, ADDR, DHI, DLO, CSUM}. Exactly one byte is consumed per cycle.
- Frame format: HEADER, ADDR (bits [3:0] used, [7:4] must be 0), DHI (bits [5:0] become c_data[13:8], [7:6] ignored), DLO (c_data[7:0]), CSUM.
- CSUM = ADDR ^ DHI ^ DLO, computed on full 8-bit bytes.
- IDLE: a popped byte equal to HEADER moves to ADDR. Any other byte is discarded silently.
- ADDR -> DHI -> DLO -> CSUM: one transition per popped byte. A HEADER value inside a frame is treated as data.
- CSUM check, in priority order:
  - checksum mismatch -> status 4'h1, back to IDLE.
  - ADDR > MAX_ADDR or ADDR[7:4] != 0 -> status 4'h2, back to IDLE.
  - otherwise -> WRITE, with c_valid=1 registered on the next cycle.
- WRITE: c_addr and c_data are stable while c_valid=1.
  - Transfer completes on a cycle with c_valid && c_ready. On the next cycle c_valid=0, status 4'h4 (write ok), state IDLE.
  - No bytes are popped during WRITE.
- Byte timeout: in ADDR/DHI/DLO/CSUM the counter increments each cycle with rx_empty=1 and clears on each pop.
  - When the counter reaches TIMEOUT-1 with no pop that cycle: status 4'h3, back to IDLE.
  - If a pop coincides with the expiry cycle, the pop wins and there is no timeout.
- Bus timeout: in WRITE the counter increments while c_ready=0.
  - When it reaches TIMEOUT-1: c_valid drops, status 4'h5, back to IDLE.
  - If c_ready=1 on the expiry cycle, the write completes with status 4'h4.
- status_valid is high for exactly one cycle per outcome. status holds its last value afterwards.
- Throughput: with a non-empty FIFO, a 5-byte frame finishes parsing in 5 cycles. c_valid rises on cycle 6, and the minimum total time back to IDLE is 7 cycles.

Optional Feature:
CFG_CHECKSUM_EN:
- Defined: frame is 5 bytes, and the CSUM state and status 4'h1 exist as described above.
- Undefined: frame is 4 bytes (HEADER, ADDR, DHI, DLO). The address check runs after DLO, the CSUM state is removed, and code 4'h1 is never generated.

Test Plan:
- Stream A5 03 01 2C 2E, c_ready=1 -> c_valid for one cycle with c_addr=3, c_data=14'h012C; status=4'h4 one cycle later.
- Stream A5 03 01 2C 2F -> no c_valid; status=4'h1 pulse; a following valid frame is then accepted.
- Stream A5 0C 00 00 0C (MAX_ADDR=11) -> status=4'h2, no write. Stream A5 13 00 00 13 -> status=4'h2.
- TIMEOUT=16; send A5 03 then stall 16 cycles -> status=4'h3 at the 16th idle cycle, state IDLE. Repeat with a byte arriving on exactly the 16th cycle -> no timeout.
- Valid frame with c_ready held 0 for 5 cycles -> c_addr/c_data stable throughout; write completes on the 6th cycle with status 4'h4. With c_ready stuck at 0 -> status=4'h5 and c_valid drops.
- Garbage bytes 00 FF 12 before A5 frame -> garbage popped silently; frame processed normally. Assert rst mid-DHI -> all outputs zero next cycle; no status pulse.

Source files
------------

// File: rtl/cfg_cmd_parser.sv
`default_nettype none
// ============================================================================
// Module  : cfg_cmd_parser
// Brief   : Turns framed UART bytes into configuration-bus writes and 4-bit
//           status codes. Define CFG_CHECKSUM_EN to add a trailing XOR byte.
// Rev     : 1.0
// ============================================================================

module cfg_cmd_parser #(
    parameter logic [7:0] HEADER   = 8'hA5,
    parameter logic [3:0] MAX_ADDR = 4'd11,
    parameter int         TIMEOUT  = 50000,
    parameter int         CNT_W    = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_empty,
    output logic        rx_rd,
    output logic        c_valid,
    output logic [3:0]  c_addr,
    output logic [13:0] c_data,
    input  logic        c_ready,
    output logic [3:0]  status,
    output logic        status_valid
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ADDR  = 3'd1,
        S_DHI   = 3'd2,
        S_DLO   = 3'd3,
`ifdef CFG_CHECKSUM_EN
        S_CSUM  = 3'd4,
`endif
        S_WRITE = 3'd5
    } state_t;

    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(TIMEOUT - 1);
`ifdef CFG_CHECKSUM_EN
    localparam logic [3:0] c_ST_CSUM = 4'h1;
`endif
    localparam logic [3:0] c_ST_ADDR = 4'h2;
    localparam logic [3:0] c_ST_TOUT = 4'h3;
    localparam logic [3:0] c_ST_OK   = 4'h4;
    localparam logic [3:0] c_ST_BUS  = 4'h5;

    state_t           r_state,  w_state_nxt;
    logic [CNT_W-1:0] r_cnt,    w_cnt_nxt;
    logic [7:0]       r_addr,   w_addr_nxt;
    logic [5:0]       r_dhi,    w_dhi_nxt;
    logic             r_cvalid, w_cvalid_nxt;
    logic [3:0]       r_caddr,  w_caddr_nxt;
    logic [13:0]      r_cdata,  w_cdata_nxt;
    logic [3:0]       r_status, w_status_nxt;
    logic             r_sv,     w_sv_nxt;
`ifdef CFG_CHECKSUM_EN
    logic [7:0]       r_dlo,    w_dlo_nxt;
    logic [7:0]       r_xor,    w_xor_nxt;
`endif

    logic       w_in_frame;
    logic       w_rd;
    logic       w_frame_end;
    logic       w_csum_bad;
    logic [7:0] w_lo;

`ifdef CFG_CHECKSUM_EN
    assign w_in_frame  = (r_state == S_ADDR) || (r_state == S_DHI) ||
                         (r_state == S_DLO)  || (r_state == S_CSUM);
`else
    assign w_in_frame  = (r_state == S_ADDR) || (r_state == S_DHI) ||
                         (r_state == S_DLO);
`endif

    // Pops are held off during reset so a byte is never lost to a discarded frame.
    assign w_rd  = !rst && !rx_empty && ((r_state == S_IDLE) || w_in_frame);
    assign rx_rd = w_rd;

`ifdef CFG_CHECKSUM_EN
    assign w_frame_end = w_rd && (r_state == S_CSUM);
    assign w_csum_bad  = (rx_data != r_xor);
    assign w_lo        = r_dlo;
`else
    assign w_frame_end = w_rd && (r_state == S_DLO);
    assign w_csum_bad  = 1'b0;
    assign w_lo        = rx_data;
`endif

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_addr_nxt   = r_addr;
        w_dhi_nxt    = r_dhi;
        w_cvalid_nxt = r_cvalid;
        w_caddr_nxt  = r_caddr;
        w_cdata_nxt  = r_cdata;
        w_status_nxt = r_status;
        w_sv_nxt     = 1'b0;
`ifdef CFG_CHECKSUM_EN
        w_dlo_nxt    = r_dlo;
        w_xor_nxt    = r_xor;
`endif

        // Inter-byte timeout: a pop on the expiry cycle takes precedence.
        if (w_in_frame) begin
            if (w_rd) begin
                w_cnt_nxt = '0;
            end else if (r_cnt == c_CNT_LAST) begin
                w_cnt_nxt    = '0;
                w_state_nxt  = S_IDLE;
                w_status_nxt = c_ST_TOUT;
                w_sv_nxt     = 1'b1;
            end else begin
                w_cnt_nxt = r_cnt + 1'b1;
            end
        end

        case (r_state)
            S_IDLE: begin
                if (w_rd && (rx_data == HEADER)) begin
                    w_state_nxt = S_ADDR;
                end
            end
            S_ADDR: begin
                if (w_rd) begin
                    w_addr_nxt  = rx_data;
                    w_state_nxt = S_DHI;
`ifdef CFG_CHECKSUM_EN
                    w_xor_nxt   = rx_data;
`endif
                end
            end
            S_DHI: begin
                if (w_rd) begin
                    w_dhi_nxt   = rx_data[5:0];
                    w_state_nxt = S_DLO;
`ifdef CFG_CHECKSUM_EN
                    w_xor_nxt   = r_xor ^ rx_data;
`endif
                end
            end
`ifdef CFG_CHECKSUM_EN
            S_DLO: begin
                if (w_rd) begin
                    w_dlo_nxt   = rx_data;
                    w_xor_nxt   = r_xor ^ rx_data;
                    w_state_nxt = S_CSUM;
                end
            end
`endif
            S_WRITE: begin
                if (c_ready) begin
                    w_cvalid_nxt = 1'b0;
                    w_status_nxt = c_ST_OK;
                    w_sv_nxt     = 1'b1;
                    w_state_nxt  = S_IDLE;
                    w_cnt_nxt    = '0;
                end else if (r_cnt == c_CNT_LAST) begin
                    w_cvalid_nxt = 1'b0;
                    w_status_nxt = c_ST_BUS;
                    w_sv_nxt     = 1'b1;
                    w_state_nxt  = S_IDLE;
                    w_cnt_nxt    = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: ;
        endcase

        // Last byte of the frame: checksum first, then address range.
        if (w_frame_end) begin
            w_state_nxt = S_IDLE;
            if (w_csum_bad) begin
`ifdef CFG_CHECKSUM_EN
                w_status_nxt = c_ST_CSUM;
`endif
                w_sv_nxt     = 1'b1;
            end else if (r_addr > {4'h0, MAX_ADDR}) begin
                w_status_nxt = c_ST_ADDR;
                w_sv_nxt     = 1'b1;
            end else begin
                w_state_nxt  = S_WRITE;
                w_cvalid_nxt = 1'b1;
                w_caddr_nxt  = r_addr[3:0];
                w_cdata_nxt  = {r_dhi, w_lo};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_addr   <= '0;
            r_dhi    <= '0;
            r_cvalid <= 1'b0;
            r_caddr  <= '0;
            r_cdata  <= '0;
            r_status <= '0;
            r_sv     <= 1'b0;
`ifdef CFG_CHECKSUM_EN
            r_dlo    <= '0;
            r_xor    <= '0;
`endif
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_addr   <= w_addr_nxt;
            r_dhi    <= w_dhi_nxt;
            r_cvalid <= w_cvalid_nxt;
            r_caddr  <= w_caddr_nxt;
            r_cdata  <= w_cdata_nxt;
            r_status <= w_status_nxt;
            r_sv     <= w_sv_nxt;
`ifdef CFG_CHECKSUM_EN
            r_dlo    <= w_dlo_nxt;
            r_xor    <= w_xor_nxt;
`endif
        end
    end

    assign c_valid      = r_cvalid;
    assign c_addr       = r_caddr;
    assign c_data       = r_cdata;
    assign status       = r_status;
    assign status_valid = r_sv;

endmodule

`default_nettype wire
